// File: rtl/ay_bus_pkg.sv
// Shared constants for the AY/PSG bus master: op codes, bus codes and FSM states.
// Bus codes are ordered {BDIR, BC2, BC1}.
package ay_bus_pkg;

   localparam logic [2:0] OpLatch = 3'b000;
   localparam logic [2:0] OpWrite = 3'b001;
   localparam logic [2:0] OpRead  = 3'b010;
   localparam logic [2:0] OpConf  = 3'b011;
   localparam logic [2:0] OpWrreg = 3'b100;
   localparam logic [2:0] OpRdreg = 3'b101;

   localparam logic [2:0] BusInact = 3'b010;
   localparam logic [2:0] BusAddr  = 3'b111;
   localparam logic [2:0] BusWr    = 3'b110;
   localparam logic [2:0] BusRd    = 3'b011;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSetup  = 3'd1;
   localparam logic [2:0] StStrobe = 3'd2;
   localparam logic [2:0] StHold   = 3'd3;
   localparam logic [2:0] StWait   = 3'd4;

   function automatic logic is_reserved(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// Loadable 10-bit down-counter timing every bus phase; o_done marks the last
// cycle of a phase that was loaded with its length.
module ay_phase_timer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [9:0] i_value,
   output logic       o_done
);

   logic [9:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 10'd0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != 10'd0) begin
         r_cnt <= r_cnt - 10'd1;
      end
   end

   assign o_done = (r_cnt == 10'd1);

endmodule

// File: rtl/ay_bus_master.sv
// Host-side AY/PSG bus initiator: turns register requests into timed
// SETUP/STROBE/HOLD/WAIT bus cycles, with LATCH+WRITE/READ composites.
module ay_bus_master
   import ay_bus_pkg::*;
#(
   parameter int unsigned T_SU  = 2,
   parameter int unsigned T_STB = 8,
   parameter int unsigned T_HLD = 2,
   parameter int unsigned T_AW  = 140,
   parameter int unsigned T_DW  = 672
) (
   input  logic       fclk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       aybdir,
   output logic       aybc1,
   output logic       aybc2,
   output logic       aya8,
   output logic       aya9_n,
   output logic [7:0] ayd_o,
   output logic       ayd_oe,
   input  logic [7:0] ayd_i
);

   localparam logic [9:0] LdSu  = 10'(T_SU);
   localparam logic [9:0] LdStb = 10'(T_STB);
   localparam logic [9:0] LdHld = 10'(T_HLD);
   localparam logic [9:0] LdAw  = 10'(T_AW);
   localparam logic [9:0] LdDw  = 10'(T_DW);

   logic [2:0] r_state;
   logic [2:0] r_code;
   logic [7:0] r_dout;
   logic [2:0] r_op;
   logic [7:0] r_data;
   logic       r_second;
   logic       r_relaunch;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;

   logic       w_accept;
   logic       w_rsvd;
   logic       w_load;
   logic [9:0] w_load_val;
   logic       w_done;
   logic       w_addr_phase;
   logic [2:0] w_bus;

   assign w_accept = req_valid && (r_state == StIdle);
   assign w_rsvd   = is_reserved(req_op);

   ay_phase_timer u_timer (
      .i_clk   (fclk),
      .i_rst   (rst),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_done  (w_done)
   );

   // The relaunch cycle between composite halves spends one extra SETUP cycle
   // so each bus cycle keeps its own launch slot.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = 10'd0;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_load     = 1'b1;
               w_load_val = w_rsvd ? 10'd1 : LdSu;
            end
         end
         StSetup: begin
            if (r_relaunch) begin
               w_load     = 1'b1;
               w_load_val = LdSu;
            end else if (w_done) begin
               w_load     = 1'b1;
               w_load_val = LdStb;
            end
         end
         StStrobe: begin
            if (w_done) begin
               w_load     = 1'b1;
               w_load_val = LdHld;
            end
         end
         StHold: begin
            if (w_done) begin
               w_load     = 1'b1;
               w_load_val = (r_code == BusAddr) ? LdAw : LdDw;
            end
         end
         StWait: begin
            if (w_done && r_second) begin
               w_load     = 1'b1;
               w_load_val = 10'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_code     <= BusInact;
         r_dout     <= 8'h00;
         r_op       <= OpLatch;
         r_data     <= 8'h00;
         r_second   <= 1'b0;
         r_relaunch <= 1'b0;
         r_rd_data  <= 8'h00;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_op       <= req_op;
                  r_data     <= req_data;
                  r_relaunch <= 1'b0;
                  r_second   <= (req_op == OpWrreg) || (req_op == OpRdreg);
                  r_state    <= w_rsvd ? StWait : StSetup;
                  case (req_op)
                     OpLatch, OpWrreg, OpRdreg: begin
                        r_code <= BusAddr;
                        r_dout <= req_addr;
                     end
                     OpWrite: begin
                        r_code <= BusWr;
                        r_dout <= req_data;
                     end
                     OpRead: begin
                        r_code <= BusRd;
                        r_dout <= 8'h00;
                     end
                     OpConf: begin
                        r_code <= BusAddr;
                        r_dout <= {4'hF, req_data[3:0]};
                     end
                     default: begin
                        r_code <= BusInact;
                        r_dout <= 8'h00;
                     end
                  endcase
               end
            end
            StSetup: begin
               if (r_relaunch) begin
                  r_relaunch <= 1'b0;
               end else if (w_done) begin
                  r_state <= StStrobe;
               end
            end
            StStrobe: begin
               if (w_done) begin
                  r_state <= StHold;
                  if (r_code == BusRd) begin
                     r_rd_data  <= ayd_i;
                     r_rd_valid <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (w_done) r_state <= StWait;
            end
            StWait: begin
               if (w_done) begin
                  if (r_second) begin
                     r_second   <= 1'b0;
                     r_relaunch <= 1'b1;
                     r_state    <= StSetup;
                     r_code     <= (r_op == OpWrreg) ? BusWr : BusRd;
                     r_dout     <= (r_op == OpWrreg) ? r_data : 8'h00;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      w_addr_phase = (r_state == StSetup) || (r_state == StStrobe) || (r_state == StHold);
      w_bus        = (r_state == StStrobe) ? r_code : BusInact;
      aybdir       = w_bus[2];
      aybc2        = w_bus[1];
      aybc1        = w_bus[0];
      aya8         = w_addr_phase;
      aya9_n       = ~w_addr_phase;
      ayd_oe       = w_addr_phase && (r_code != BusRd);
      ayd_o        = ayd_oe ? r_dout : 8'h00;
      req_ready    = (r_state == StIdle);
      rd_valid     = r_rd_valid;
      rd_data      = r_rd_data;
   end

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: a per-cycle waveform model built from the bus timing
// rules, directed cases with literal timings, then randomized traffic.
module tb_ay_bus_master;

   localparam int unsigned T_SU  = 2;
   localparam int unsigned T_STB = 8;
   localparam int unsigned T_HLD = 2;
   localparam int unsigned T_AW  = 140;
   localparam int unsigned T_DW  = 672;

   localparam logic [2:0] INACT = 3'b010;
   localparam logic [2:0] ADDR  = 3'b111;
   localparam logic [2:0] WR    = 3'b110;
   localparam logic [2:0] RD    = 3'b011;

   logic       fclk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       aybdir, aybc1, aybc2, aya8, aya9_n, ayd_oe;
   logic [7:0] ayd_o;
   logic [7:0] ayd_i;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0] code;
      logic       a8;
      logic       oe;
      logic [7:0] dout;
      logic       rdv;
      logic       smp;
   } exp_t;

   exp_t mq[$];

   ay_bus_master #(
      .T_SU (T_SU),
      .T_STB(T_STB),
      .T_HLD(T_HLD),
      .T_AW (T_AW),
      .T_DW (T_DW)
   ) dut (
      .fclk     (fclk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_addr (req_addr),
      .req_data (req_data),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .aybdir   (aybdir),
      .aybc1    (aybc1),
      .aybc2    (aybc2),
      .aya8     (aya8),
      .aya9_n   (aya9_n),
      .ayd_o    (ayd_o),
      .ayd_oe   (ayd_oe),
      .ayd_i    (ayd_i)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 50) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // One bus cycle as a list of per-cycle expected outputs.
   task automatic push_bus(input logic [2:0] code, input logic [7:0] dout,
                           input int unsigned tw, input int unsigned extra);
      exp_t e;
      e = '{code: INACT, a8: 1'b1, oe: (code != RD), dout: dout, rdv: 1'b0, smp: 1'b0};
      for (int i = 0; i < int'(T_SU + extra); i++) mq.push_back(e);
      e.code = code;
      for (int i = 0; i < int'(T_STB); i++) begin
         e.smp = (code == RD) && (i == int'(T_STB) - 1);
         mq.push_back(e);
      end
      e.code = INACT;
      e.smp  = 1'b0;
      for (int i = 0; i < int'(T_HLD); i++) begin
         e.rdv = (code == RD) && (i == 0);
         mq.push_back(e);
      end
      e = '{code: INACT, a8: 1'b0, oe: 1'b0, dout: 8'h00, rdv: 1'b0, smp: 1'b0};
      for (int i = 0; i < int'(tw); i++) mq.push_back(e);
   endtask

   task automatic model_accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      case (op)
         3'd0: push_bus(ADDR, a, T_AW, 0);
         3'd1: push_bus(WR, d, T_DW, 0);
         3'd2: push_bus(RD, 8'h00, T_DW, 0);
         3'd3: push_bus(ADDR, {4'hF, d[3:0]}, T_AW, 0);
         3'd4: begin
            push_bus(ADDR, a, T_AW, 0);
            push_bus(WR, d, T_DW, 1);
         end
         3'd5: begin
            push_bus(ADDR, a, T_AW, 0);
            push_bus(RD, 8'h00, T_DW, 1);
         end
         default: begin
            e = '{code: INACT, a8: 1'b0, oe: 1'b0, dout: 8'h00, rdv: 1'b0, smp: 1'b0};
            mq.push_back(e);
         end
      endcase
   endtask

   // Compare process: checks every cycle at the falling edge.
   initial begin
      exp_t       cur;
      bit         idle_now;
      logic [7:0] m_rd;
      m_rd = 8'h00;
      @(posedge fclk);
      forever begin
         @(negedge fclk);
         idle_now = (mq.size() == 0);
         if (idle_now) cur = '{code: INACT, a8: 1'b0, oe: 1'b0, dout: 8'h00, rdv: 1'b0, smp: 1'b0};
         else cur = mq.pop_front();
         chk("bus_code", 32'({aybdir, aybc2, aybc1}), 32'(cur.code));
         chk("addr_lines", 32'({aya8, aya9_n}), 32'({cur.a8, ~cur.a8}));
         chk("ayd_oe", 32'(ayd_oe), 32'(cur.oe));
         if (cur.oe || idle_now) chk("ayd_o", 32'(ayd_o), 32'(cur.dout));
         chk("req_ready", 32'(req_ready), 32'(idle_now));
         chk("rd_valid", 32'(rd_valid), 32'(cur.rdv));
         chk("rd_data", 32'(rd_data), 32'(m_rd));
         if (rst) begin
            mq.delete();
            m_rd = 8'h00;
         end else begin
            if (cur.smp) m_rd = ayd_i;
            if (idle_now && req_valid) model_accept(req_op, req_addr, req_data);
         end
      end
   end

   // Trace of the last directed op, indexed by cycle after acceptance.
   logic [2:0] tr_code[0:1299];
   logic       tr_a8[0:1299];
   logic       tr_oe[0:1299];
   logic [7:0] tr_dout[0:1299];
   logic       tr_rdv[0:1299];
   int         tr_len;

   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
      req_op    = op;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      for (int i = 0; i < 2000 && !req_ready; i++) begin
         @(posedge fclk);
         #1;
      end
      chk("ready_before_op", 32'(req_ready), 32'd1);
      @(posedge fclk);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_addr  = 8'($urandom);
      req_data  = 8'($urandom);
      tr_len    = 1;
      while (!req_ready && tr_len < 1200) begin
         tr_code[tr_len] = {aybdir, aybc2, aybc1};
         tr_a8[tr_len]   = aya8;
         tr_oe[tr_len]   = ayd_oe;
         tr_dout[tr_len] = ayd_o;
         tr_rdv[tr_len]  = rd_valid;
         @(posedge fclk);
         #1;
         tr_len++;
      end
   endtask

   function automatic int count_code(input logic [2:0] c);
      int n = 0;
      for (int i = 1; i < tr_len; i++) if (tr_code[i] == c) n++;
      return n;
   endfunction

   function automatic int first_code(input logic [2:0] c);
      for (int i = 1; i < tr_len; i++) if (tr_code[i] == c) return i;
      return -1;
   endfunction

   function automatic int count_code_dout(input logic [2:0] c, input logic [7:0] d);
      int n = 0;
      for (int i = 1; i < tr_len; i++) if (tr_code[i] == c && tr_dout[i] == d) n++;
      return n;
   endfunction

   initial begin
      int n, nfirst;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'd0;
      req_addr  = 8'h00;
      req_data  = 8'h00;
      ayd_i     = 8'h00;
      repeat (3) @(posedge fclk);
      #1;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_bus", 32'({aybdir, aybc2, aybc1, aya8, aya9_n, ayd_oe}), 32'b010_0_1_0);
      chk("reset_rd", 32'({rd_valid, rd_data, ayd_o}), 32'd0);
      rst = 1'b0;

      // LATCH 0x07
      run_op(3'd0, 8'h07, 8'h00);
      chk("latch_ready_cycle", 32'(tr_len), 32'd153);
      chk("latch_addr_start", 32'(first_code(ADDR)), 32'd3);
      chk("latch_addr_len", 32'(count_code(ADDR)), 32'd8);
      n = 0;
      for (int i = 1; i < tr_len; i++) if (tr_oe[i] && tr_dout[i] == 8'h07) n++;
      chk("latch_drive_cycles", 32'(n), 32'd12);

      // WRREG 0x28 <- 0xF0
      run_op(3'd4, 8'h28, 8'hF0);
      chk("wrreg_ready_cycle", 32'(tr_len), 32'd838);
      chk("wrreg_addr_len", 32'(count_code_dout(ADDR, 8'h28)), 32'd8);
      chk("wrreg_wr_len", 32'(count_code_dout(WR, 8'hF0)), 32'd8);
      nfirst = first_code(WR);
      n = 0;
      for (int i = 1; i < nfirst; i++) if (!tr_a8[i]) n++;
      chk("wrreg_addr_wait", 32'(n), 32'd140);

      // RDREG 0x00 with the bus returning 0x5A
      ayd_i = 8'h5A;
      run_op(3'd5, 8'h00, 8'h00);
      chk("rdreg_ready_cycle", 32'(tr_len), 32'd838);
      n = 0;
      for (int i = 1; i < tr_len; i++) if (tr_oe[i]) n++;
      chk("rdreg_oe_only_latch", 32'(n), 32'd12);
      chk("rdreg_rd_len", 32'(count_code(RD)), 32'd8);
      n = 0;
      for (int i = 1; i < tr_len; i++) if (tr_rdv[i]) n++;
      chk("rdreg_rd_valid_pulses", 32'(n), 32'd1);
      chk("rdreg_rd_data", 32'(rd_data), 32'h5A);
      ayd_i = 8'h00;

      // CONF 0x3
      run_op(3'd3, 8'h00, 8'h03);
      chk("conf_addr_f3", 32'(count_code_dout(ADDR, 8'hF3)), 32'd8);
      n = 0;
      for (int i = 1; i < tr_len; i++) if (!tr_a8[i]) n++;
      chk("conf_wait", 32'(n), 32'd140);
      chk("conf_ready_cycle", 32'(tr_len), 32'd153);

      // Reserved op 110
      run_op(3'd6, 8'h55, 8'hAA);
      chk("rsvd_ready_cycle", 32'(tr_len), 32'd2);
      chk("rsvd_no_bus", 32'(count_code(INACT)), 32'(tr_len - 1));
      chk("rsvd_rd_data_kept", 32'(rd_data), 32'h5A);

      // Reset during the STROBE of a WRITE
      req_op    = 3'd1;
      req_data  = 8'hA5;
      req_valid = 1'b1;
      @(posedge fclk);
      #1;
      req_valid = 1'b0;
      for (int i = 0; i < 50 && {aybdir, aybc2, aybc1} != WR; i++) begin
         @(posedge fclk);
         #1;
      end
      chk("rst_test_in_strobe", 32'({aybdir, aybc2, aybc1}), 32'(WR));
      rst = 1'b1;
      @(posedge fclk);
      #1;
      rst = 1'b0;
      chk("rst_bus", 32'({aybdir, aybc2, aybc1, aya8, ayd_oe, req_ready}), 32'b010_0_0_1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if ({aybdir, aybc2, aybc1} != INACT || rd_valid) n++;
         @(posedge fclk);
         #1;
      end
      chk("rst_no_more_strobes", 32'(n), 32'd0);

      // Randomized traffic; req_valid mostly high gives back-to-back requests.
      for (int c = 0; c < 25000; c++) begin
         int r;
         r         = int'($urandom_range(0, 19));
         req_op    = (r < 18) ? 3'(r / 3) : ((r == 18) ? 3'd6 : 3'd7);
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = 8'($urandom);
         req_data  = 8'($urandom);
         ayd_i     = 8'($urandom);
         rst       = ($urandom_range(0, 2999) == 0);
         @(posedge fclk);
         #1;
      end
      rst       = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 2000 && !req_ready; i++) begin
         @(posedge fclk);
         #1;
      end
      chk("final_idle", 32'(req_ready), 32'd1);
      repeat (3) @(posedge fclk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ay_bus_master.md
# ay_bus_master

Host-side initiator for the AY-compatible PSG bus that drives a TurboFMpro sound board. It accepts register-level requests from a CPU core or test sequencer and generates correctly timed BDIR/BC1/BC2 bus cycles, chip-address strobes and data drive. It covers address latch, data write, data read, configuration write, and combined address+data register accesses. Read data is returned on a response strobe. The block sits between the host core and the board connector, at the far end of the bus the board's bridge decodes.

## Interface
Parameters (all values in fclk cycles, each in the range 1..1023):
- T_SU, 2: setup cycles before the strobe (address/data stable, bus code inactive).
- T_STB, 8: strobe width.
- T_HLD, 2: hold cycles after the strobe (data still driven).
- T_AW, 140: wait after an address-latch or config cycle (YM2203 address wait ≈17 master clocks at 3.5 MHz).
- T_DW, 672: wait after a data write or read cycle (YM2203 data wait ≈83 master clocks).

Ports:
- fclk  in  1  system clock, 28 MHz; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready at a rising fclk edge.
- req_op  in  3  operation: 000 LATCH, 001 WRITE, 010 READ, 011 CONF, 100 WRREG, 101 RDREG; 110 and 111 reserved.
- req_addr  in  8  register address (LATCH, WRREG, RDREG).
- req_data  in  8  write data (WRITE, WRREG); CONF uses bits [3:0].
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  8  last sampled read byte; holds its value between reads.
- aybdir, aybc1, aybc2  out  1 each  PSG bus control.
- aya8  out  1  chip address line, active high.
- aya9_n  out  1  chip address line, active low.
- ayd_o  out  8  data to the bus.
- ayd_oe  out  1  data drive enable (the top level builds the tristate).
- ayd_i  in  8  data from the bus, synchronous to fclk (registered at the top level).

## Operation
- Bus codes {BDIR,BC2,BC1}: INACT = 010, ADDR = 111, WR = 110, RD = 011.
- Each bus cycle runs the states SETUP → STROBE → HOLD → WAIT.
  - SETUP: INACT, aya8 = 1, aya9_n = 0.
  - STROBE: the op's bus code.
  - HOLD: INACT, address lines still asserted.
  - WAIT: INACT, aya8 = 0, aya9_n = 1, ayd_oe = 0.
- ayd_oe = 1 in SETUP, STROBE and HOLD for ADDR and WR cycles; 0 in all states of an RD cycle.
- ayd_o per op:
  - LATCH: req_addr.
  - WRITE: req_data.
  - CONF: {4'hF, req_data[3:0]}, carried on an ADDR cycle that the board decodes as a config write.
- A LATCH with req_addr[7:4] = F is a config write by bus definition. It is passed through unchanged.
- WRREG = LATCH(req_addr), then WRITE(req_data).
- RDREG = LATCH(req_addr), then READ.
- The second bus cycle of WRREG/RDREG starts right after the first cycle's WAIT (T_AW) with no IDLE cycle in between.
- WAIT length is T_AW after ADDR-code cycles and T_DW after WR/RD cycles.
- Reserved ops are accepted and completed in one cycle with no bus activity and no rd_valid.
- Request fields are captured at acceptance; later changes to the inputs have no effect.

## Timing
- Reset (and the IDLE state): aybdir = 0, aybc2 = 1, aybc1 = 0, aya8 = 0, aya9_n = 1, ayd_oe = 0, ayd_o = 0, rd_valid = 0, rd_data = 0, req_ready = 1.
- Request accepted at edge N: SETUP occupies cycles N+1 .. N+T_SU; STROBE follows for T_STB cycles, then HOLD for T_HLD cycles, then WAIT.
- Single-cycle op: req_ready returns high exactly 1 + T_SU + T_STB + T_HLD + T_W cycles after acceptance, where T_W is T_AW or T_DW as above.
- Composite op: the sum of its two bus cycles.
- Read: ayd_i is registered into rd_data at the edge ending the last STROBE cycle. rd_valid is high for exactly the first HOLD cycle.
- Bus codes change only at state boundaries; no single-cycle glitch codes appear between states.
- ADDR and WR codes are never emitted while aya8 = 0.
- rst mid-operation: at the next edge all outputs take their reset values, the operation is abandoned, no rd_valid is issued, and req_ready = 1.
- req_valid held high in IDLE with a new request: back-to-back acceptance with no gap cycle beyond the WAIT period.

## Structure
- Package ay_bus_pkg: op code localparams, 3-bit bus code constants, and the state enum (IDLE, SETUP, STROBE, HOLD, WAIT).
- Sub-module ay_phase_timer: 10-bit loadable down-counter with load value, load strobe and a done flag. It is reused for all phase lengths.
- Top-level FSM in ay_bus_master. A second-cycle flag sequences the WRREG/RDREG ops.

## Test plan
- LATCH 0x07 with defaults:
  - bus code 111 for exactly 8 cycles, starting 3 cycles after acceptance.
  - ayd_o = 0x07 with ayd_oe = 1 for 12 cycles.
  - req_ready returns high at cycle 153.
- WRREG addr 0x28, data 0xF0:
  - ADDR cycle, then 140 cycles of WAIT.
  - WR code 110 for 8 cycles with ayd_o = 0xF0.
  - req_ready returns high at 838.
- RDREG addr 0x00, with the bench driving ayd_i = 0x5A during STROBE:
  - ayd_oe = 0 throughout the RD cycle.
  - rd_valid pulses once, with rd_data = 0x5A.
- CONF with data 0x3:
  - ADDR code with ayd_o = 0xF3.
  - WAIT of T_AW.
- rst asserted during the STROBE of a WRITE: next cycle shows bus 010, aya8 = 0, ayd_oe = 0, req_ready = 1, and no further strobes.
- Reserved op 110 → req_ready is low for one cycle, with no bus activity and no rd_valid.
